// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt priority controller.
package irq_pkg;

    localparam int unsigned IRQ_MAX          = 8;
    localparam int unsigned VECTOR_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IRQ_REG_PENDING = 2'd0,
        IRQ_REG_ENABLE  = 2'd1,
        IRQ_REG_MODE    = 2'd2,
        IRQ_REG_VECTOR  = 2'd3
    } irq_reg_e;

    // Lowest-numbered set bit wins; an empty vector yields 0.
    function automatic logic [2:0] irq_lowest_idx(input logic [IRQ_MAX-1:0] vec);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < IRQ_MAX; i++) begin
            if (vec[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_line_sync.sv
// Per-line input conditioning: optional 2-flop synchroniser (IRQ_SYNC_EN) and
// falling-edge detector on the conditioned active-low request.
module irq_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic irqb,
    output logic level,
    output logic fall_pulse
);

    logic irqb_s;
    logic hist_q;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], irqb};
        end
    end

    assign irqb_s = sync_q[1];
`else
    assign irqb_s = irqb;
`endif

    // History always tracks the line, so a line already low never produces a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= irqb_s;
        end
    end

    assign level      = irqb_s;
    assign fall_pulse = hist_q & ~irqb_s;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Prioritised, maskable interrupt controller driving the 65C02 IRQB pin.
// Define IRQ_SYNC_EN to synchronise request inputs from foreign clock domains.
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned     NUM_IRQ        = 8,
    parameter logic [7:0]      DEFAULT_ENABLE = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cs,
    input  logic               rwb,
    input  logic [1:0]         addr,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    input  logic [NUM_IRQ-1:0] irqb,
    output logic               irqb_master
);

    localparam int unsigned          MASK_INT  = (1 << NUM_IRQ) - 1;
    localparam logic [IRQ_MAX-1:0]   LINE_MASK = MASK_INT[IRQ_MAX-1:0];

    logic [IRQ_MAX-1:0] level;
    logic [IRQ_MAX-1:0] fall_pulse;

    logic [IRQ_MAX-1:0] pending_q, pending_d;
    logic [IRQ_MAX-1:0] enable_q, enable_d;
    logic [IRQ_MAX-1:0] mode_q, mode_d;
    logic [IRQ_MAX-1:0] clr_mask;
    logic [IRQ_MAX-1:0] active;
    logic [IRQ_MAX-1:0] edge_next;
    logic [2:0]         vec_idx;
    logic               vec_valid;
    logic [7:0]         vec_rd;
    logic               master_q;
    logic               wr_en;
    irq_reg_e           reg_sel;

    for (genvar g = 0; g < IRQ_MAX; g++) begin : g_line
        if (g < NUM_IRQ) begin : g_used
            irq_line_sync u_line (
                .clk        (clk),
                .reset_n    (reset_n),
                .irqb       (irqb[g]),
                .level      (level[g]),
                .fall_pulse (fall_pulse[g])
            );
        end else begin : g_unused
            assign level[g]      = 1'b1;
            assign fall_pulse[g] = 1'b0;
        end
    end

    assign reg_sel   = irq_reg_e'(addr);
    assign wr_en     = cs & ~rwb;
    assign active    = pending_q & enable_q;
    assign vec_valid = |active;
    assign vec_idx   = irq_lowest_idx(active);

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        clr_mask = '0;
        if (wr_en) begin
            unique case (reg_sel)
                IRQ_REG_PENDING: clr_mask = i_data;
                IRQ_REG_ENABLE:  enable_d = i_data & LINE_MASK;
                IRQ_REG_MODE:    mode_d   = i_data & LINE_MASK;
                IRQ_REG_VECTOR: begin
                    if (vec_valid) begin
                        clr_mask = IRQ_MAX'(1) << vec_idx;
                    end
                end
            endcase
        end
    end

    // Set beats clear; a bit entering edge mode this cycle starts cleared;
    // a bit in (or entering) level mode loads the line state directly.
    always_comb begin
        edge_next = (pending_q & ~clr_mask) | fall_pulse;
        pending_d = ((mode_d & mode_q & edge_next) | (~mode_d & ~level)) & LINE_MASK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            enable_q  <= DEFAULT_ENABLE & LINE_MASK;
            mode_q    <= '0;
            master_q  <= 1'b1;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            master_q  <= ~vec_valid;
        end
    end

    assign irqb_master = master_q;

    always_comb begin
        vec_rd                   = '0;
        vec_rd[VECTOR_VALID_BIT] = vec_valid;
        vec_rd[2:0]              = vec_idx;
    end

    always_comb begin
        o_data = '0;
        if (cs) begin
            unique case (reg_sel)
                IRQ_REG_PENDING: o_data = pending_q;
                IRQ_REG_ENABLE:  o_data = enable_q;
                IRQ_REG_MODE:    o_data = mode_q;
                IRQ_REG_VECTOR:  o_data = vec_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl: register table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_irq_priority_ctrl;

    localparam int NUM = 8;
`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs      = 1'b0;
    logic       rwb     = 1'b1;
    logic [1:0] addr    = 2'd0;
    logic [7:0] i_data  = 8'h00;
    logic [7:0] irqb    = 8'hFF;
    logic [7:0] o_data;
    logic       irqb_master;

    always #5 clk = ~clk;

    irq_priority_ctrl #(
        .NUM_IRQ        (8),
        .DEFAULT_ENABLE (8'h00)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cs          (cs),
        .rwb         (rwb),
        .addr        (addr),
        .i_data      (i_data),
        .o_data      (o_data),
        .irqb        (irqb),
        .irqb_master (irqb_master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus the delayed view of irqb.
    logic [7:0] m_pend, m_en, m_mode, m_prev_s;
    logic       m_master;
    logic [7:0] m_sq[$];

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < NUM; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] cur_s();
        if (SYNC == 0) return irqb;
        return m_sq[0];
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_prev_s = 8'hFF; m_master = 1'b1;
        m_sq.delete();
        for (int i = 0; i < SYNC; i++) m_sq.push_back(8'hFF);
    endtask

    function automatic logic [7:0] model_read();
        int idx;
        if (!cs) return 8'h00;
        idx = lowest(m_pend & m_en);
        case (addr)
            2'd0:    return m_pend;
            2'd1:    return m_en;
            2'd2:    return m_mode;
            default: return (idx < 0) ? 8'h00 : (8'h80 | 8'(idx));
        endcase
    endfunction

    task automatic model_clock();
        logic [7:0] s, np;
        logic       wr, valid, newmode;
        int         idx;
        s     = cur_s();
        wr    = cs && !rwb;
        idx   = lowest(m_pend & m_en);
        valid = (idx >= 0);
        np    = m_pend;
        for (int i = 0; i < NUM; i++) begin
            newmode = (wr && addr == 2'd2) ? i_data[i] : m_mode[i];
            if (!newmode)                      np[i] = !s[i];
            else if (!m_mode[i])               np[i] = 1'b0;
            else if (m_prev_s[i] && !s[i])     np[i] = 1'b1;
            else if (wr && ((addr == 2'd0 && i_data[i]) || (addr == 2'd3 && valid && idx == i)))
                                               np[i] = 1'b0;
        end
        m_master = !valid;
        if (wr && addr == 2'd1) m_en   = i_data;
        if (wr && addr == 2'd2) m_mode = i_data;
        m_pend   = np;
        m_prev_s = s;
        if (SYNC > 0) begin
            m_sq.push_back(irqb);
            void'(m_sq.pop_front());
        end
    endtask

    // One bus cycle: drive, sample on the falling edge, then advance the model.
    task automatic cyc(input logic c, input logic r, input logic [1:0] a, input logic [7:0] d,
                       output logic [7:0] od, output logic m);
        cs = c; rwb = r; addr = a; i_data = d;
        @(negedge clk);
        od = o_data;
        m  = irqb_master;
        check("model_odata", od, model_read());
        check("model_master", {7'b0, m}, {7'b0, m_master});
        @(posedge clk);
        model_clock();
        #1;
    endtask

    logic [7:0] od;
    logic       mm;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 8'h00, od, mm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, a, d, od, mm);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string nm);
        cyc(1'b1, 1'b1, a, 8'h00, od, mm);
        check(nm, od, exp);
    endtask

    task automatic master_chk(input logic exp, input string nm);
        cyc(1'b0, 1'b1, 2'd0, 8'h00, od, mm);
        check(nm, {7'b0, mm}, {7'b0, exp});
    endtask

    task automatic pulse(input logic [7:0] lines);
        irqb = ~lines;
        idle(1);
        irqb = 8'hFF;
    endtask

    typedef struct {
        logic       c;
        logic       r;
        logic [1:0] a;
        logic [7:0] wd;
        logic [7:0] exp_od;
        logic       exp_m;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_low;

        tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 2'd1, 8'hA5, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 2'd1, 8'h00, 8'hA5, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'd2, 8'h3C, 8'h00, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h3C, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'd3, 8'h12, 8'h00, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'hA5, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h3C, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1};

        // Reset, then release between edges with the bus idle.
        model_reset();
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            cyc(tbl[i].c, tbl[i].r, tbl[i].a, tbl[i].wd, od, mm);
            check($sformatf("table[%0d].o_data", i), od, tbl[i].exp_od);
            check($sformatf("table[%0d].master", i), {7'b0, mm}, {7'b0, tbl[i].exp_m});
        end

        // Edge latch latency and VECTOR acknowledge.
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h01);
        idle(1);
        pulse(8'h01);
        first_low = 0;
        for (int j = 1; j <= 10; j++) begin
            idle(1);
            if (mm == 1'b0) begin
                first_low = j;
                break;
            end
        end
        check("edge_latency", 8'(first_low), 8'(SYNC + 2));
        rd_chk(2'd3, 8'h80, "edge_vector");
        wr(2'd3, 8'h00);
        rd_chk(2'd0, 8'h00, "edge_pending_cleared");
        master_chk(1'b1, "edge_master_released");

        // Priority between simultaneous edges.
        wr(2'd1, 8'hFF);
        idle(1);
        pulse(8'h24);
        idle(SYNC + 2);
        rd_chk(2'd3, 8'h82, "prio_first");
        wr(2'd3, 8'h55);
        rd_chk(2'd3, 8'h85, "prio_second");
        wr(2'd3, 8'h00);
        rd_chk(2'd3, 8'h00, "prio_empty");
        master_chk(1'b1, "prio_master");

        // Masked pending bit, then enable.
        wr(2'd1, 8'h00);
        pulse(8'h08);
        idle(SYNC + 2);
        rd_chk(2'd0, 8'h08, "mask_pending_visible");
        master_chk(1'b1, "mask_master_high");
        wr(2'd1, 8'h08);
        master_chk(1'b1, "mask_enable_write_edge");
        master_chk(1'b0, "mask_enable_next");
        wr(2'd0, 8'h08);
        idle(2);

        // Level mode follows the line; W1C has no effect.
        wr(2'd2, 8'h00);
        wr(2'd1, 8'hFF);
        irqb = 8'hFD;
        idle(SYNC + 2);
        rd_chk(2'd0, 8'h02, "level_pending");
        master_chk(1'b0, "level_master_low");
        wr(2'd0, 8'h02);
        rd_chk(2'd0, 8'h02, "level_w1c_ignored");
        irqb = 8'hFF;
        idle(SYNC + 2);
        rd_chk(2'd0, 8'h00, "level_released");
        master_chk(1'b1, "level_master_high");

        // Switching a held-low line to edge mode must not latch it.
        irqb = 8'hF7;
        idle(SYNC + 2);
        rd_chk(2'd0, 8'h08, "held_low_level");
        wr(2'd2, 8'h08);
        rd_chk(2'd0, 8'h00, "mode_to_edge_clears");
        idle(3);
        rd_chk(2'd0, 8'h00, "held_low_no_latch");
        irqb = 8'hFF;
        idle(SYNC + 2);

        // A new edge coinciding with W1C of the same bit keeps it set.
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h00);
        pulse(8'h10);
        idle(SYNC + 2);
        rd_chk(2'd0, 8'h10, "collision_pre");
        for (int k = 0; k <= SYNC; k++) begin
            irqb = (k == 0) ? 8'hEF : 8'hFF;
            if (k == SYNC) wr(2'd0, 8'h10);
            else           idle(1);
        end
        irqb = 8'hFF;
        rd_chk(2'd0, 8'h10, "collision_set_wins");
        wr(2'd0, 8'h10);
        rd_chk(2'd0, 8'h00, "collision_cleared");

        // Asynchronous reset while a request is active.
        wr(2'd1, 8'h01);
        pulse(8'h01);
        idle(SYNC + 3);
        master_chk(1'b0, "pre_reset_master");
        reset_n = 1'b0;
        #1;
        check("reset_async_master", {7'b0, irqb_master}, 8'h01);
        cs = 1'b1; rwb = 1'b1; addr = 2'd3;
        #1;
        check("reset_vector", o_data, 8'h00);
        cs = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd_chk(2'd0, 8'h00, "post_reset_pending");
        rd_chk(2'd1, 8'h00, "post_reset_enable");
        rd_chk(2'd2, 8'h00, "post_reset_mode");
        rd_chk(2'd3, 8'h00, "post_reset_vector");
        master_chk(1'b1, "post_reset_master");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) irqb[$urandom_range(0, 7)] ^= 1'b1;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                2'($urandom_range(0, 3)), 8'($urandom), od, mm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
